// File: rtl/sad_pkg.sv
// Shared SAD-engine sizing and the minimum-finder state encoding.
// Both the SAD engine and the minimum finder import this package.
package sad_pkg;
    localparam int CA_WIDTH = 7;
    localparam int R_WIDTH  = 32;
    localparam int ENTRIES  = 128;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        CMP  = 3'd3,
        FIN  = 3'd4
    } state_t;
endpackage

// File: rtl/sad_min_finder_min_tracker.sv
// Running minimum of a stream of values, remembering where it was first seen.
// A strict less-than compare means ties keep the earliest index.
module min_tracker #(
    parameter int CA_WIDTH = sad_pkg::CA_WIDTH,
    parameter int R_WIDTH  = sad_pkg::R_WIDTH
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                clr,
    input  logic                en,
    input  logic [R_WIDTH-1:0]  val,
    input  logic [CA_WIDTH-1:0] idx,
    output logic [R_WIDTH-1:0]  best,
    output logic [CA_WIDTH-1:0] best_idx
);
    always_ff @(posedge Clk) begin
        if (Rst) begin
            best     <= '0;
            best_idx <= '0;
        end else if (clr) begin
            best     <= '1;
            best_idx <= '0;
        end else if (en && (val < best)) begin
            best     <= val;
            best_idx <= idx;
        end
    end
endmodule

// File: rtl/sad_min_finder.sv
// Scans the SAD result memory once per Start and reports the smallest value
// and its address. Each entry costs REQ/WAIT/CMP = 3 cycles.
module sad_min_finder #(
    parameter int CA_WIDTH = sad_pkg::CA_WIDTH,
    parameter int R_WIDTH  = sad_pkg::R_WIDTH,
    parameter int ENTRIES  = sad_pkg::ENTRIES
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start,
    output logic [CA_WIDTH-1:0] C_Addr,
    output logic                C_RW,
    output logic                C_En,
    input  logic [R_WIDTH-1:0]  C_Data,
    output logic                Busy,
    output logic [R_WIDTH-1:0]  Min_Val,
    output logic [CA_WIDTH-1:0] Min_Idx,
    output logic                Done
);
    import sad_pkg::*;

    state_t state, state_n;

    // One extra bit so the counter cannot wrap back to 0 unnoticed.
    logic [CA_WIDTH:0]   idx;
    logic                last, start_ok;
    logic [R_WIDTH-1:0]  best;
    logic [CA_WIDTH-1:0] best_idx;

    assign last     = (idx == (CA_WIDTH+1)'(ENTRIES-1));
    // A Start coinciding with the Done pulse belongs to the finished run.
    assign start_ok = Start && !Done;
    assign Busy     = (state != IDLE);
    assign C_RW     = 1'b0;

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_ok) state_n = REQ;
            REQ:     state_n = WAIT;
            WAIT:    state_n = CMP;
            CMP:     state_n = last ? FIN : REQ;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            idx     <= '0;
            C_En    <= 1'b0;
            C_Addr  <= '0;
            Done    <= 1'b0;
            Min_Val <= '0;
            Min_Idx <= '0;
        end else begin
            C_En   <= (state == REQ);
            C_Addr <= (state == REQ) ? idx[CA_WIDTH-1:0] : '0;
            Done   <= (state == FIN);
            if (state == IDLE && start_ok) idx <= '0;
            else if (state == CMP && !last) idx <= idx + 1'b1;
            if (state == FIN) begin
                Min_Val <= best;
                Min_Idx <= best_idx;
            end
        end
    end

    min_tracker #(.CA_WIDTH(CA_WIDTH), .R_WIDTH(R_WIDTH)) u_trk (
        .Clk      (Clk),
        .Rst      (Rst),
        .clr      (state == IDLE && start_ok),
        .en       (state == CMP),
        .val      (C_Data),
        .idx      (idx[CA_WIDTH-1:0]),
        .best     (best),
        .best_idx (best_idx)
    );
endmodule

// File: tb/tb_sad_min_finder.sv
// Scoreboarded bench for sad_min_finder against a one-cycle-latency memory model.
module tb_sad_min_finder;
    localparam int CA = 7;
    localparam int RW = 32;
    localparam int N  = 128;

    logic          Clk = 0, Rst = 1, Start = 0;
    logic [CA-1:0] C_Addr, Min_Idx;
    logic          C_RW, C_En, Busy, Done;
    logic [RW-1:0] C_Data = '0, Min_Val;

    logic [RW-1:0] mem [N];
    logic [RW+CA-1:0] sb_q [$];

    int n_tests = 0, n_fail = 0;
    int cyc = 0, en_cnt = 0, done_cnt = 0, last_en = 0, addr_next = 0;
    logic [RW-1:0] last_val = '0;
    logic [CA-1:0] last_idx = '0;

    sad_min_finder dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .C_Addr(C_Addr), .C_RW(C_RW),
        .C_En(C_En), .C_Data(C_Data), .Busy(Busy), .Min_Val(Min_Val),
        .Min_Idx(Min_Idx), .Done(Done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        cyc++;
        if (C_En && !C_RW) C_Data <= mem[C_Addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Bus monitor and scoreboard sink.
    always @(negedge Clk) begin
        if (!Busy) addr_next = 0;
        if (C_En) begin
            chk("c_addr_seq", 64'(C_Addr), 64'(addr_next));
            chk("c_rw", 64'(C_RW), 0);
            if (addr_next != 0) chk("c_en_gap", 64'(cyc - last_en), 3);
            last_en = cyc;
            addr_next++;
            en_cnt++;
        end else begin
            chk("c_addr_idle", 64'(C_Addr), 0);
        end
        if (Done) begin
            done_cnt++;
            if (sb_q.size() == 0) chk("spurious_done", 1, 0);
            else begin
                logic [RW+CA-1:0] e;
                e = sb_q.pop_front();
                chk("min_val", 64'(Min_Val), 64'(e[RW+CA-1:CA]));
                chk("min_idx", 64'(Min_Idx), 64'(e[CA-1:0]));
            end
        end
    end

    function automatic logic [RW+CA-1:0] model_min();
        logic [RW-1:0] b;
        logic [CA-1:0] bi;
        b = '1; bi = '0;
        for (int i = 0; i < N; i++)
            if (mem[i] < b) begin b = mem[i]; bi = CA'(i); end
        return {b, bi};
    endfunction

    task automatic run_scan(input bit repulse, input int abort_at);
        logic [RW+CA-1:0] e;
        int cnt, en0, d0;
        e = model_min();
        if (abort_at == 0) sb_q.push_back(e);
        en0 = en_cnt; d0 = done_cnt;
        @(negedge Clk) Start = 1;
        @(posedge Clk);
        @(negedge Clk) Start = 0;
        cnt = 0;
        while (cnt < 500) begin
            @(posedge Clk); cnt++;
            @(negedge Clk);
            Start = repulse && (cnt == 10 || cnt == 200);
            if (cnt == 100) begin
                chk("hold_val", 64'(Min_Val), 64'(last_val));
                chk("hold_idx", 64'(Min_Idx), 64'(last_idx));
                chk("busy_scan", 64'(Busy), 1);
            end
            if (abort_at != 0 && cnt == abort_at) begin
                Rst = 1;
                @(posedge Clk);
                @(negedge Clk) Rst = 0;
                chk("abort_outs", {C_Addr, C_RW, C_En, Busy, Done}, 0);
                chk("abort_min", {Min_Val, Min_Idx}, 0);
                repeat (400) @(negedge Clk);
                #1 chk("abort_no_done", 64'(done_cnt), 64'(d0));
                last_val = '0; last_idx = '0;
                return;
            end
            if (Done) break;
        end
        chk("done_edge", 64'(cnt), 385);
        // Start during the Done cycle must not launch a run.
        Start = 1;
        @(posedge Clk);
        @(negedge Clk) Start = 0;
        chk("start_on_done", 64'(Busy), 0);
        repeat (3) @(negedge Clk);
        #1;
        chk("en_pulses", 64'(en_cnt - en0), 128);
        chk("done_pulses", 64'(done_cnt - d0), 1);
        last_val = e[RW+CA-1:CA]; last_idx = e[CA-1:0];
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_outs", {C_Addr, C_RW, C_En, Busy, Done}, 0);
        chk("rst_min", {Min_Val, Min_Idx}, 0);
        Rst = 0;
        repeat (2) @(negedge Clk);
        chk("idle_busy", 64'(Busy), 0);

        for (int i = 0; i < N; i++) mem[i] = RW'(1000 - i);
        run_scan(0, 0);

        for (int i = 0; i < N; i++) mem[i] = 500;
        mem[20] = 7; mem[90] = 7;
        run_scan(0, 0);

        for (int i = 0; i < N; i++) mem[i] = '1;
        run_scan(0, 0);

        for (int i = 0; i < N; i++) mem[i] = 32'(i * 3 + 40);
        mem[64] = 5;
        run_scan(1, 0);

        run_scan(0, 150);
        run_scan(0, 0);

        mem[0] = 0;
        for (int i = 1; i < N; i++) mem[i] = $urandom;
        run_scan(0, 0);

        chk("sb_empty", 64'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sad_min_finder.md
SAD_MIN_FINDER -- requirements
Module: sad_min_finder

Interface
REQ-001 Parameter CA_WIDTH, default 7, result-memory address width.
REQ-002 Parameter R_WIDTH, default 32, SAD result width.
REQ-003 Parameter ENTRIES, default 128, number of SAD results scanned per run.
REQ-004 Clk  input  1  clock; all state changes on rising edge.
REQ-005 Rst  input  1  reset, synchronous, active-high.
REQ-006 Start  input  1  run request; connected to the SAD engine's Done pulse.
REQ-007 C_Addr  output  CA_WIDTH  result-memory read address.
REQ-008 C_RW  output  1  result-memory read/write select; always 0 (read).
REQ-009 C_En  output  1  result-memory enable.
REQ-010 C_Data  input  R_WIDTH  result-memory read data.
REQ-011 Busy  output  1  high while a scan is in progress.
REQ-012 Min_Val  output  R_WIDTH  smallest SAD found by last completed scan.
REQ-013 Min_Idx  output  CA_WIDTH  address of that smallest SAD.
REQ-014 Done  output  1  one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, CMP, FIN.
REQ-016 IDLE: Start=1 at an edge SHALL go to REQ, clear index to 0, set running best to all-ones, set running best index to 0; Start=0 stays IDLE.
REQ-017 REQ: drive C_Addr=index, C_En=1, C_RW=0 (registered) and go to WAIT.
REQ-018 C_En SHALL be high for exactly one cycle per entry; C_Addr SHALL be 0 whenever C_En=0.
REQ-019 WAIT: no action and go to CMP (memory has one-cycle synchronous read latency).
REQ-020 CMP: sample C_Data; if C_Data < running best (unsigned, strict), load best=C_Data and best index=index.
REQ-021 CMP: if index = ENTRIES-1 go to FIN, else increment index and go to REQ.
REQ-022 Ties SHALL keep the lowest index (strict compare).
REQ-023 FIN: copy best/best index to Min_Val/Min_Idx, pulse Done=1 for one cycle, go to IDLE.
REQ-024 Per-entry cost SHALL be exactly 3 cycles. Done SHALL be high in the cycle after the 3*ENTRIES+1-th rising edge following the edge that sampled Start; for ENTRIES=128 that is edge 385.
REQ-025 Busy SHALL be 1 in REQ, WAIT, CMP and FIN, and 0 in IDLE.
REQ-026 Start SHALL be ignored while Busy=1.
REQ-027 Start in the same cycle as Done SHALL be ignored; a new run needs Start while in IDLE.
REQ-028 Min_Val/Min_Idx SHALL hold their values between Done pulses and SHALL not change during a scan.
REQ-029 If all entries equal all-ones, the result SHALL be Min_Val=0xFFFFFFFF and Min_Idx=0.
REQ-030 The index counter SHALL be CA_WIDTH+1 bits or compared before increment so that it never wraps silently.

Reset
REQ-031 Rst=1 SHALL force IDLE and set C_Addr=0, C_RW=0, C_En=0, Busy=0, Done=0, Min_Val=0, Min_Idx=0, and index/best to 0, with priority over all other inputs.
REQ-032 Rst asserted mid-scan SHALL abort the scan with no Done pulse; the next Start SHALL begin a full scan from index 0.

Structure
REQ-033 Shared package sad_pkg SHALL hold CA_WIDTH, R_WIDTH, ENTRIES and the state encodings, and SHALL be shared with the SAD engine.
REQ-034 One sub-module min_tracker (compare/update of best value and index, with clear and enable) is natural; the FSM stays in sad_min_finder.

Verification
REQ-035 Memory holds value 1000-i at address i; Start pulse -> Done at edge 385, Min_Val=873, Min_Idx=127.
REQ-036 Memory holds all 500 except addresses 20 and 90 =  7 -> Min_Val=7, Min_Idx=20 (tie goes to the lowest index).
REQ-037 Memory all 0xFFFFFFFF -> Min_Val=0xFFFFFFFF, Min_Idx=0.
REQ-038 Start re-pulsed at cycles 10 and 200 during a scan -> only one Done, at edge 385; C_En pulses counted = 128.
REQ-039 Rst asserted at cycle 150 of a scan -> all outputs 0 the next cycle, no Done; Start again -> full 385-cycle scan with correct result.
REQ-040 Address 0 = 0, rest random -> Min_Val=0, Min_Idx=0; C_Addr sequence 0..127 observed, each 3 cycles apart.
